// File: rtl/rotary_led_ctrl.sv
// Rotary-encoder front end: synchronise, debounce and decode quadrature steps into a position shown on LEDs.
// Optional build macro ROTARY_LED_SATURATE_EN clamps the position at its limits instead of wrapping.
module rotary_led_ctrl #(
    parameter int LED_WIDTH        = 8,
    parameter int POS_WIDTH        = 8,
    parameter int DEBOUNCE         = 4,
    parameter int STEPS_PER_DETENT = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [1:0]           rotary,
    input  logic                 mode,
    output logic [LED_WIDTH-1:0] leds,
    output logic [POS_WIDTH-1:0] position,
    output logic                 step,
    output logic                 dir,
    output logic                 err
);

    localparam int                   LED_IDX_W = $clog2(LED_WIDTH);
    localparam logic [7:0]           DB_LAST   = 8'(DEBOUNCE - 1);
    localparam logic signed [3:0]    SPD_POS   = 4'(STEPS_PER_DETENT);
    localparam logic signed [3:0]    SPD_NEG   = 4'sd0 - SPD_POS;
    localparam logic [POS_WIDTH-1:0] POS_ONE   = {{(POS_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [POS_WIDTH-1:0] POS_ZERO  = {POS_WIDTH{1'b0}};
    localparam logic [POS_WIDTH-1:0] POS_MAX   = {POS_WIDTH{1'b1}};
    localparam logic [LED_WIDTH-1:0] LED_ONE   = {{(LED_WIDTH-1){1'b0}}, 1'b1};

    logic [1:0]           r_sync1;
    logic [1:0]           r_sync2;
    logic [1:0]           r_deb;
    logic [1:0]           r_prev;
    logic [7:0]           r_db_cnt [2];
    logic signed [3:0]    r_acc;

    logic signed [3:0]    w_acc_step;
    logic signed [3:0]    w_acc_next;
    logic [POS_WIDTH-1:0] w_pos_next;
    logic [1:0]           w_idx_cw;
    logic                 w_step;
    logic                 w_dir;
    logic                 w_err;

    // Position of a Gray pair within the CW cycle 00 -> 01 -> 11 -> 10.
    function automatic logic [1:0] gray_idx(input logic [1:0] pair);
        case (pair)
            2'b00:   gray_idx = 2'd0;
            2'b01:   gray_idx = 2'd1;
            2'b11:   gray_idx = 2'd2;
            2'b10:   gray_idx = 2'd3;
            default: gray_idx = 2'd0;
        endcase
    endfunction

    function automatic logic [LED_WIDTH-1:0] led_view(input logic [POS_WIDTH-1:0] pos,
                                                      input logic              bin_mode);
        if (bin_mode) begin
            led_view = LED_WIDTH'(pos);
        end else begin
            led_view = LED_ONE << pos[LED_IDX_W-1:0];
        end
    endfunction

    // Two-flop synchroniser for the asynchronous encoder lines.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_sync1 <= 2'b00;
            r_sync2 <= 2'b00;
        end else begin
            r_sync1 <= rotary;
            r_sync2 <= r_sync1;
        end
    end

    // Per-bit debouncer: a bit flips only after DEBOUNCE consecutive disagreeing samples.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_deb       <= 2'b00;
            r_db_cnt[0] <= 8'd0;
            r_db_cnt[1] <= 8'd0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (r_sync2[i] == r_deb[i]) begin
                    r_db_cnt[i] <= 8'd0;
                end else if (r_db_cnt[i] == DB_LAST) begin
                    r_deb[i]    <= ~r_deb[i];
                    r_db_cnt[i] <= 8'd0;
                end else begin
                    r_db_cnt[i] <= r_db_cnt[i] + 8'd1;
                end
            end
        end
    end

    assign w_idx_cw = gray_idx(r_prev) + 2'd1;

    // Transition decode, detent accumulation and next position.
    always_comb begin
        w_acc_step = r_acc;
        w_acc_next = r_acc;
        w_pos_next = position;
        w_step     = 1'b0;
        w_dir      = 1'b0;
        w_err      = 1'b0;
        if (r_deb != r_prev) begin
            if ((r_deb ^ r_prev) == 2'b11) begin
                w_err      = 1'b1;
                w_acc_next = 4'sd0;
            end else begin
                if (gray_idx(r_deb) == w_idx_cw) begin
                    w_acc_step = r_acc + 4'sd1;
                end else begin
                    w_acc_step = r_acc - 4'sd1;
                end
                if (w_acc_step == SPD_POS) begin
                    w_step     = 1'b1;
                    w_dir      = 1'b1;
                    w_acc_next = 4'sd0;
`ifdef ROTARY_LED_SATURATE_EN
                    if (position != POS_MAX) begin
                        w_pos_next = position + POS_ONE;
                    end else begin
                        w_pos_next = position;
                    end
`else
                    w_pos_next = position + POS_ONE;
`endif
                end else if (w_acc_step == SPD_NEG) begin
                    w_step     = 1'b1;
                    w_dir      = 1'b0;
                    w_acc_next = 4'sd0;
`ifdef ROTARY_LED_SATURATE_EN
                    if (position != POS_ZERO) begin
                        w_pos_next = position - POS_ONE;
                    end else begin
                        w_pos_next = position;
                    end
`else
                    w_pos_next = position - POS_ONE;
`endif
                end else begin
                    w_acc_next = w_acc_step;
                end
            end
        end else begin
            w_acc_next = r_acc;
        end
    end

    // Decoder state and registered outputs; LEDs always follow the next position.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_prev   <= 2'b00;
            r_acc    <= 4'sd0;
            position <= POS_ZERO;
            step     <= 1'b0;
            dir      <= 1'b0;
            err      <= 1'b0;
            leds     <= {LED_WIDTH{1'b0}};
        end else begin
            r_prev   <= r_deb;
            r_acc    <= w_acc_next;
            position <= w_pos_next;
            step     <= w_step;
            dir      <= w_dir;
            err      <= w_err;
            leds     <= led_view(w_pos_next, mode);
        end
    end

endmodule
